// File: rtl/xbus_pkg.sv
// Shared constants and types for the two-master xbus arbiter.
package xbus_pkg;

    localparam int XBUS_ADDR_W = 32;
    localparam int XBUS_DATA_W = 32;
    localparam int XBUS_BE_W   = XBUS_DATA_W / 8;

    localparam int ARB_RR    = 0;
    localparam int ARB_FIXED = 1;

    typedef enum logic {
        OWN_M0 = 1'b0,
        OWN_M1 = 1'b1
    } owner_e;

endpackage

// File: rtl/xbus_if.sv
// Master-side request/response link and RAM-side slave link of the xbus.
interface xbus_if #(
    parameter int ADDR_W = xbus_pkg::XBUS_ADDR_W,
    parameter int DATA_W = xbus_pkg::XBUS_DATA_W
);
    localparam int BE_W = DATA_W / 8;

    logic              req;
    logic              we;
    logic [BE_W-1:0]   be;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              gnt;
    logic              rvalid;
    logic [DATA_W-1:0] rdata;

    modport master (output req, we, be, addr, wdata, input gnt, rvalid, rdata);
    modport slave  (input req, we, be, addr, wdata, output gnt, rvalid, rdata);
endinterface

interface xbus_mem_if #(
    parameter int ADDR_W = xbus_pkg::XBUS_ADDR_W,
    parameter int DATA_W = xbus_pkg::XBUS_DATA_W
);
    localparam int BE_W = DATA_W / 8;

    logic              cs;
    logic              we;
    logic [BE_W-1:0]   be;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;

    modport master (output cs, we, be, addr, wdata, input rdata);
    modport slave  (input cs, we, be, addr, wdata, output rdata);
endinterface

// File: rtl/xbus_arb_pick.sv
// Combinational two-way chooser: round-robin or m0-priority with a starvation override.
module xbus_arb_pick
    import xbus_pkg::*;
#(
    parameter int ARB_MODE = ARB_RR
) (
    input  logic   req0,
    input  logic   req1,
    input  owner_e last_gnt,
    input  logic   starve_hit,
    output logic   gnt0,
    output logic   gnt1
);

    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (req0 && req1) begin
            if (ARB_MODE == ARB_FIXED) begin
                if (starve_hit) gnt1 = 1'b1;
                else            gnt0 = 1'b1;
            end else begin
                if (last_gnt == OWN_M1) gnt0 = 1'b1;
                else                    gnt1 = 1'b1;
            end
        end else begin
            gnt0 = req0;
            gnt1 = req1;
        end
    end

endmodule

// File: rtl/xbus_arbiter.sv
// Two-master arbiter in front of a single-port RAM with 1-cycle read latency;
// read data is tagged back to the master that issued the read.
module xbus_arbiter
    import xbus_pkg::*;
#(
    parameter int ADDR_W       = XBUS_ADDR_W,
    parameter int DATA_W       = XBUS_DATA_W,
    parameter int ARB_MODE     = ARB_RR,
    parameter int STARVE_LIMIT = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    xbus_if.slave        m0,
    xbus_if.slave        m1,
    xbus_mem_if.master   s
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    owner_e           last_gnt;
    owner_e           last_gnt_nxt;
    logic [CNT_W-1:0] starve_cnt;
    logic [CNT_W-1:0] starve_cnt_nxt;
    logic             rvalid0_q;
    logic             rvalid1_q;
    logic             pick0;
    logic             pick1;
    logic             gnt0;
    logic             gnt1;
    logic             starve_hit;

    assign starve_hit = (starve_cnt == CNT_W'(STARVE_LIMIT)) && m1.req;

    xbus_arb_pick #(
        .ARB_MODE (ARB_MODE)
    ) u_pick (
        .req0       (m0.req),
        .req1       (m1.req),
        .last_gnt   (last_gnt),
        .starve_hit (starve_hit),
        .gnt0       (pick0),
        .gnt1       (pick1)
    );

    // Grants are combinational, so they must be forced low while reset is held.
    assign gnt0 = pick0 & rst_n;
    assign gnt1 = pick1 & rst_n;

    always_comb begin
        last_gnt_nxt   = last_gnt;
        starve_cnt_nxt = starve_cnt;
        if (gnt0)      last_gnt_nxt = OWN_M0;
        else if (gnt1) last_gnt_nxt = OWN_M1;
        if (!m1.req || gnt1) begin
            starve_cnt_nxt = '0;
        end else if (gnt0 && (starve_cnt != CNT_W'(STARVE_LIMIT))) begin
            starve_cnt_nxt = starve_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_gnt   <= OWN_M1;
            starve_cnt <= '0;
            rvalid0_q  <= 1'b0;
            rvalid1_q  <= 1'b0;
        end else begin
            last_gnt   <= last_gnt_nxt;
            starve_cnt <= starve_cnt_nxt;
            rvalid0_q  <= gnt0 & ~m0.we;
            rvalid1_q  <= gnt1 & ~m1.we;
        end
    end

    always_comb begin
        s.cs    = gnt0 | gnt1;
        s.we    = 1'b0;
        s.be    = '0;
        s.addr  = m0.addr;
        s.wdata = m0.wdata;
        if (gnt1) begin
            s.we    = m1.we;
            s.be    = m1.be;
            s.addr  = m1.addr;
            s.wdata = m1.wdata;
        end else if (gnt0) begin
            s.we    = m0.we;
            s.be    = m0.be;
        end
        if (!rst_n) begin
            s.addr  = '0;
            s.wdata = '0;
        end
    end

    assign m0.gnt    = gnt0;
    assign m1.gnt    = gnt1;
    assign m0.rvalid = rvalid0_q;
    assign m1.rvalid = rvalid1_q;
    assign m0.rdata  = rst_n ? s.rdata : '0;
    assign m1.rdata  = rst_n ? s.rdata : '0;

endmodule
